// File: rtl/de2_115_sopc_cpu_mulx_pkg.sv
// Shared encodings and constants for the multi-cycle high-word multiply sequencer.
package de2_115_sopc_cpu_mulx_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXSS = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXUU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CORR,
    DONE
  } state_e;

  localparam int LATENCY = 7;

  // Partial-product shifts, in units of PP_W, for issue slots 0..3.
  localparam int unsigned PP_SHIFT0 = 0;
  localparam int unsigned PP_SHIFT1 = 1;
  localparam int unsigned PP_SHIFT2 = 1;
  localparam int unsigned PP_SHIFT3 = 2;

  function automatic int unsigned pp_shift(input logic [1:0] idx, input int unsigned pp_w);
    case (idx)
      2'd0:    return PP_SHIFT0 * pp_w;
      2'd1:    return PP_SHIFT1 * pp_w;
      2'd2:    return PP_SHIFT2 * pp_w;
      default: return PP_SHIFT3 * pp_w;
    endcase
  endfunction

endpackage

// File: rtl/de2_115_sopc_cpu_mulx_pp.sv
// Registered PP_W x PP_W unsigned multiplier; one-cycle latency, maps onto a DSP block.
module de2_115_sopc_cpu_mulx_pp #(
  parameter int PP_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PP_W-1:0]   a,
  input  logic [PP_W-1:0]   b,
  output logic [2*PP_W-1:0] p
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
    end else begin
      p <= {{PP_W{1'b0}}, a} * {{PP_W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/de2_115_sopc_cpu_mulx_seq.sv
// Multi-cycle MUL/MULX sequencer: four partial products through one shared
// multiplier, accumulated into a 64-bit sum, then sign-corrected on the high word.
module de2_115_sopc_cpu_mulx_seq
  import de2_115_sopc_cpu_mulx_pkg::*;
#(
  parameter int PP_W   = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  if (DATA_W != 2 * PP_W) begin : g_bad_width
    $error("DATA_W must equal 2*PP_W");
  end

  state_e              state;
  logic [1:0]          cnt;
  op_e                 op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [2*DATA_W-1:0] acc;
  logic [PP_W-1:0]     mul_a;
  logic [PP_W-1:0]     mul_b;
  logic [2*PP_W-1:0]   pp;
  logic [1:0]          acc_idx;
  logic                acc_en;
  logic [2*DATA_W-1:0] pp_ext;
  logic [DATA_W-1:0]   hi_word;
  logic [DATA_W-1:0]   corr_hi;

  // cnt bit 0 picks the A half and bit 1 the B half, giving lo*lo, hi*lo, lo*hi, hi*hi.
  always_comb begin
    mul_a = cnt[0] ? a_q[DATA_W-1:PP_W] : a_q[PP_W-1:0];
    mul_b = cnt[1] ? b_q[DATA_W-1:PP_W] : b_q[PP_W-1:0];
  end

  de2_115_sopc_cpu_mulx_pp #(
    .PP_W(PP_W)
  ) u_pp (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (mul_a),
    .b       (mul_b),
    .p       (pp)
  );

  // The product on pp belongs to the slot issued one cycle earlier.
  always_comb begin
    acc_en  = 1'b0;
    acc_idx = 2'd3;
    if (state == ISSUE && cnt != 2'd0) begin
      acc_en  = 1'b1;
      acc_idx = cnt - 2'd1;
    end else if (state == DRAIN) begin
      acc_en  = 1'b1;
    end
    pp_ext = {{(2*DATA_W-2*PP_W){1'b0}}, pp} << pp_shift(acc_idx, PP_W);
  end

  // Convert the unsigned product's high word to signed-by-signed or signed-by-unsigned.
  always_comb begin
    hi_word = acc[2*DATA_W-1:DATA_W];
    corr_hi = hi_word;
    case (op_q)
      OP_MULXSS: corr_hi = hi_word - (a_q[DATA_W-1] ? b_q : '0) - (b_q[DATA_W-1] ? a_q : '0);
      OP_MULXSU: corr_hi = hi_word - (a_q[DATA_W-1] ? b_q : '0);
      default:   corr_hi = hi_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= src1;
            b_q   <= src2;
            op_q  <= op_e'(op);
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (acc_en) begin
            acc <= acc + pp_ext;
          end
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          acc   <= acc + pp_ext;
          state <= CORR;
        end
        CORR: begin
          result <= (op_q == OP_MUL) ? acc[DATA_W-1:0] : corr_hi;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de2_115_sopc_cpu_mulx_seq.sv
// Scoreboard bench: the driver predicts acceptance and results from a 64-bit
// arithmetic model; the monitor checks busy/done/result every cycle.
module tb_de2_115_sopc_cpu_mulx_seq;
  import de2_115_sopc_cpu_mulx_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          exp_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          cyc = 0;
  int          last_k = -100;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] held_res = '0;
  exp_t        exp_q[$];

  de2_115_sopc_cpu_mulx_seq #(
    .PP_W   (16),
    .DATA_W (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae;
    logic [63:0] be;
    logic [63:0] prod;
    ae   = (o == OP_MULXSS || o == OP_MULXSU) ? {{32{a[31]}}, a} : {32'h0, a};
    be   = (o == OP_MULXSS) ? {{32{b[31]}}, b} : {32'h0, b};
    prod = ae * be;
    return (o == OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0000;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: outputs sampled on the falling edge, predictions from the last accepted start.
  always @(negedge clk) begin
    if (!reset_n) begin
      check_output("reset_busy", {31'b0, busy}, 32'h0);
      check_output("reset_done", {31'b0, done}, 32'h0);
      check_output("reset_result", result, 32'h0);
    end else begin
      check_output("busy", {31'b0, busy},
                   {31'b0, (cyc >= last_k + 1) && (cyc <= last_k + LATENCY - 1)});
      check_output("done", {31'b0, done}, {31'b0, cyc == last_k + LATENCY});
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", {31'b0, done}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("result", result, e.res);
          check_output("latency", cyc, e.exp_cyc);
          held_res = e.res;
        end
      end else begin
        check_output("result_hold", result, held_res);
      end
    end
  end

  // One cycle of stimulus; records a prediction if the sequencer will take the start.
  task automatic apply_stimulus(input bit st, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input bit use_exp, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    #1;
    start = st;
    op    = o;
    src1  = a;
    src2  = b;
    if (st && !((cyc >= last_k + 1) && (cyc <= last_k + LATENCY - 1))) begin
      e.res     = use_exp ? exp : ref_result(o, a, b);
      e.exp_cyc = cyc + LATENCY;
      exp_q.push_back(e);
      last_k = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, OP_MUL, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    apply_stimulus(1'b1, o, a, b, 1'b1, exp);
    idle(LATENCY + 1);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    start   = 1'b0;
    exp_q.delete();
    last_k   = -100;
    held_res = '0;
    #1;
    check_output("async_reset_busy", {31'b0, busy}, 32'h0);
    check_output("async_reset_done", {31'b0, done}, 32'h0);
    check_output("async_reset_result", result, 32'h0);
    repeat (n) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    run_op(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(OP_MULXSS, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op(OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(OP_MULXSS, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000);
    run_op(OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MULXSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001);
    run_op(OP_MUL,    32'h0001_2345, 32'h0000_0010, 32'h0012_3450);
    idle(3);

    // Start held high: only the IDLE and DONE-cycle samples may launch work.
    repeat (10) apply_stimulus(1'b1, OP_MULXUU, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001);
    idle(LATENCY + 1);

    // Abort mid-operation, then confirm a clean restart.
    apply_stimulus(1'b1, OP_MULXSS, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0);
    idle(2);
    apply_reset(2);
    idle(1);
    run_op(OP_MULXUU, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000);

    repeat (400) begin
      apply_stimulus($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                     pick_operand(), pick_operand(), 1'b0, 32'h0);
    end
    idle(LATENCY + 2);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_results actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
